// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcode encodings, the
// control-sequencer step encoding and the opcode field width.
package risc_pkg;

    localparam int OPC_W = 3;

    typedef logic [OPC_W-1:0] opc_t;

    localparam opc_t OPC_HLT  = 3'b000;
    localparam opc_t OPC_SKZ  = 3'b001;
    localparam opc_t OPC_ADD  = 3'b010;
    localparam opc_t OPC_ANDD = 3'b011;
    localparam opc_t OPC_XORR = 3'b100;
    localparam opc_t OPC_LDA  = 3'b101;
    localparam opc_t OPC_STO  = 3'b110;
    localparam opc_t OPC_JMP  = 3'b111;

    // S0..S7 are the eight machine-cycle steps; HALTED sits outside the loop.
    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_t;

    // Advance one step around the S0..S7 ring.
    function automatic state_t next_step(input state_t s);
        return (s == S7) ? S0 : state_t'(s + 4'd1);
    endfunction

endpackage

// File: rtl/risc_opc_class.sv
// Combinational opcode classifier used by the control sequencer.
module risc_opc_class
    import risc_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_hlt,
    output logic             is_skz,
    output logic             is_jmp,
    output logic             is_sto,
    output logic             is_alu
);

    assign is_hlt = (opcode == OPC_HLT);
    assign is_skz = (opcode == OPC_SKZ);
    assign is_jmp = (opcode == OPC_JMP);
    assign is_sto = (opcode == OPC_STO);
    // ALU class: every instruction that moves a memory operand into the accumulator.
    assign is_alu = (opcode == OPC_ADD) || (opcode == OPC_ANDD) ||
                    (opcode == OPC_XORR) || (opcode == OPC_LDA);

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Main control sequencer of the 8-bit RISC CPU. Walks a fixed eight-step
// machine cycle per instruction and drives registered control strobes.
// Optional feature: define RISC_CTRL_INSTR_CNT_EN to add the 16-bit
// retired-instruction counter output instr_cnt.
module risc_ctrl_fsm
    import risc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             load_ir,
    output logic             rd,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             wr,
    output logic             datactl_ena,
`ifdef RISC_CTRL_INSTR_CNT_EN
    output logic [15:0]      instr_cnt,
`endif
    output logic             halt
);

    state_t state;
    logic   is_hlt, is_skz, is_jmp, is_sto, is_alu;

    risc_opc_class u_opc_class (
        .opcode (opcode),
        .is_hlt (is_hlt),
        .is_skz (is_skz),
        .is_jmp (is_jmp),
        .is_sto (is_sto),
        .is_alu (is_alu)
    );

    // Step sequencer: registers the control word of the current step and advances.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S0;
            load_ir     <= 1'b0;
            rd          <= 1'b0;
            inc_pc      <= 1'b0;
            load_pc     <= 1'b0;
            load_acc    <= 1'b0;
            wr          <= 1'b0;
            datactl_ena <= 1'b0;
            halt        <= 1'b0;
        end else begin
            // NOTE: every strobe is cleared first and selectively set below; with
            // non-blocking assignments the last one in the block wins, so each
            // output is a one-cycle pulse unless its step asserts it again.
            load_ir     <= 1'b0;
            rd          <= 1'b0;
            inc_pc      <= 1'b0;
            load_pc     <= 1'b0;
            load_acc    <= 1'b0;
            wr          <= 1'b0;
            datactl_ena <= 1'b0;
            halt        <= 1'b0;

            if (state == HALTED) begin
                halt <= 1'b1;
            end else if (!ena) begin
                state <= S0;
            end else begin
                state <= next_step(state);
                case (state)
                    S0, S1: begin
                        load_ir <= 1'b1;
                        rd      <= 1'b1;
                        inc_pc  <= 1'b1;
                    end
                    S3: begin
                        if (is_hlt) begin
                            halt  <= 1'b1;
                            state <= HALTED;
                        end
                    end
                    S4: begin
                        load_pc     <= is_jmp;
                        rd          <= is_alu;
                        datactl_ena <= is_sto;
                    end
                    S5: begin
                        rd          <= is_alu;
                        load_acc    <= is_alu;
                        load_pc     <= is_jmp;
                        inc_pc      <= is_jmp | (is_skz & zero);
                        wr          <= is_sto;
                        datactl_ena <= is_sto;
                    end
                    S6: begin
                        rd          <= is_alu;
                        datactl_ena <= is_sto;
                    end
                    S7: begin
                        inc_pc <= is_skz & zero;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RISC_CTRL_INSTR_CNT_EN
    // Retired-instruction counter: counts each completed S7 -> S0 wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_cnt <= 16'd0;
        end else if (ena && state == S7) begin
            instr_cnt <= instr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Self-checking bench for risc_ctrl_fsm: directed sequences followed by
// randomized stimulus, checked through an expected-response queue.
module tb_risc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic       zero = 1'b0;
    logic       load_ir, rd, inc_pc, load_pc, load_acc, wr, datactl_ena, halt;
`ifdef RISC_CTRL_INSTR_CNT_EN
    logic [15:0] instr_cnt;
`endif

    risc_ctrl_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .load_ir     (load_ir),
        .rd          (rd),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .wr          (wr),
        .datactl_ena (datactl_ena),
`ifdef RISC_CTRL_INSTR_CNT_EN
        .instr_cnt   (instr_cnt),
`endif
        .halt        (halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  outs;   // {load_ir, rd, inc_pc, load_pc, load_acc, wr, datactl_ena, halt}
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    // Reference model state: position in the machine cycle, halt flag, retired count.
    int          m_step   = 0;
    bit          m_halted = 1'b0;
    logic [15:0] m_cnt    = 16'd0;

    // Control word demanded by the instruction table for one step.
    function automatic logic [7:0] ctrl_word(input int step, input logic [2:0] opc, input logic z);
        bit li = 0, r = 0, ip = 0, lp = 0, la = 0, w = 0, de = 0, h = 0;
        bit alu = (opc == 3'd2) || (opc == 3'd3) || (opc == 3'd4) || (opc == 3'd5);
        bit sto = (opc == 3'd6);
        bit jmp = (opc == 3'd7);
        bit skz = (opc == 3'd1);
        if (step == 0 || step == 1) begin
            li = 1; r = 1; ip = 1;
        end else if (step == 3) begin
            h = (opc == 3'd0);
        end else if (step == 4) begin
            lp = jmp; r = alu; de = sto;
        end else if (step == 5) begin
            r = alu; la = alu; lp = jmp; ip = jmp || (skz && z); w = sto; de = sto;
        end else if (step == 6) begin
            r = alu; de = sto;
        end else if (step == 7) begin
            ip = skz && z;
        end
        return {li, r, ip, lp, la, w, de, h};
    endfunction

    // Drive one cycle of inputs and queue what the next edge must produce.
    task automatic drive(input logic r_n, input logic e, input logic [2:0] o, input logic z);
        exp_t ex;
        @(negedge clk);
        rst = r_n; ena = e; opcode = o; zero = z;
        if (!r_n) begin
            ex.outs = 8'h00; m_step = 0; m_halted = 0; m_cnt = 16'd0;
        end else if (m_halted) begin
            ex.outs = 8'h01;
        end else if (!e) begin
            ex.outs = 8'h00; m_step = 0;
        end else begin
            ex.outs = ctrl_word(m_step, o, z);
            if (m_step == 3 && o == 3'd0) begin
                m_halted = 1;
            end else begin
                if (m_step == 7) m_cnt = m_cnt + 16'd1;
                m_step = (m_step + 1) % 8;
            end
        end
        ex.cnt = m_cnt;
        ex.tag = phase;
        exp_q.push_back(ex);
    endtask

    task automatic run_instr(input logic [2:0] o, input logic z);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, o, z);
    endtask

    // Monitor: after each edge, compare the DUT against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t ex;
                logic [7:0] act;
                ex  = exp_q.pop_front();
                act = {load_ir, rd, inc_pc, load_pc, load_acc, wr, datactl_ena, halt};
                checks++;
                if (act !== ex.outs) begin
                    errors++;
                    $display("FAIL %s outs: got %b expected %b (t=%0t)", ex.tag, act, ex.outs, $time);
                end
                checks++;
                if (rd === 1'b1 && wr === 1'b1) begin
                    errors++;
                    $display("FAIL %s rd_wr_exclusive: got rd=1 wr=1 expected not both (t=%0t)", ex.tag, $time);
                end
`ifdef RISC_CTRL_INSTR_CNT_EN
                checks++;
                if (instr_cnt !== ex.cnt) begin
                    errors++;
                    $display("FAIL %s instr_cnt: got %0d expected %0d (t=%0t)", ex.tag, instr_cnt, ex.cnt, $time);
                end
`endif
            end
        end
    end

    // Stimulus: directed test-plan sequences, then randomized traffic.
    initial begin
        logic [2:0] rnd_opc;
        phase = "reset";
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 3'd5, 1'b0);
        phase = "idle";
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 3'd5, 1'b0);

        phase = "lda";    run_instr(3'd5, 1'b0);
        phase = "sto";    run_instr(3'd6, 1'b0);
        phase = "skz_z1"; run_instr(3'd1, 1'b1);
        phase = "skz_z0"; run_instr(3'd1, 1'b0);
        phase = "jmp";    run_instr(3'd7, 1'b0);

        phase = "abort";
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 3'd2, 1'b0);
        drive(1'b1, 1'b0, 3'd2, 1'b0);
        phase = "add3";
        for (int k = 0; k < 3; k++) run_instr(3'd2, 1'b0);

        phase = "hlt";
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 3'd0, 1'b0);
        phase = "halted";
        for (int i = 0; i < 20; i++) drive(1'b1, logic'(i % 2), 3'($urandom_range(0, 7)), 1'($urandom));
        phase = "hlt_reset";
        drive(1'b0, 1'b1, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 1'b0);

        phase   = "random";
        rnd_opc = 3'd2;
        for (int i = 0; i < 600; i++) begin
            if (m_step == 0) begin
                rnd_opc = 3'($urandom_range(0, 7));
                if (rnd_opc == 3'd0 && $urandom_range(0, 3) != 0) rnd_opc = 3'd5;
            end
            drive(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 9) != 0),
                  rnd_opc, 1'($urandom));
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_ctrl_fsm.md
# risc_ctrl_fsm

- Main control sequencer of the 8-bit RISC CPU; sits directly downstream of the instruction register and consumes its opcode field (opc_iraddr[15:13]).
- Steps through a fixed 8-step machine cycle per instruction and drives:
  - the instruction-register load enable (feeding the IR's ena);
  - PC increment/load, accumulator load, memory rd/wr, data-bus driver enable and halt.
- All outputs are registered.

## Interface
- No parameters. Opcode encodings and step numbering come from the shared package.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- ena  in  1  run enable from the top-level start logic; low holds the sequencer idle
- opcode  in  3  instruction opcode = IR opc_iraddr[15:13]
- zero  in  1  accumulator-is-zero flag
- load_ir  out  1  IR byte-load enable (drives IR ena)
- rd  out  1  memory read strobe
- inc_pc  out  1  program-counter increment
- load_pc  out  1  program-counter load from IR address
- load_acc  out  1  accumulator load from ALU
- wr  out  1  memory write strobe
- datactl_ena  out  1  enables accumulator onto data bus
- halt  out  1  processor halted (sticky until reset)

## Operation
- Opcodes:
  - HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
  - ALU class = ADD, ANDD, XORR, LDA.
- States: S0..S7 (3-bit step counter) plus HALTED.
- Each edge in step Sk registers the control word for Sk and advances to Sk+1 (S7→S0). Signals not listed for a step are 0.
  - S0: load_ir, rd, inc_pc (fetch high byte).
  - S1: load_ir, rd, inc_pc (fetch low byte).
  - S2: all 0 (decode gap).
  - S3:
    - HLT: halt=1, next state HALTED.
    - Otherwise all 0.
  - S4:
    - JMP: load_pc.
    - ALU class: rd.
    - STO: datactl_ena.
    - Otherwise 0.
  - S5:
    - ALU class: rd, load_acc.
    - JMP: load_pc, inc_pc.
    - STO: wr, datactl_ena.
    - SKZ with zero=1: inc_pc.
  - S6:
    - ALU class: rd.
    - STO: datactl_ena.
    - Otherwise 0.
  - S7:
    - SKZ with zero=1: inc_pc.
    - Otherwise 0.
- HALTED: halt=1, all other outputs 0; only rst leaves it. ena is ignored.
- ena=0 in any non-HALTED state: next state S0, all outputs 0. Resumes at S0 fetch when ena returns to 1.
- Sampling:
  - opcode is sampled at S3..S7 only.
  - zero is sampled at S5 and S7 independently.
- wr and rd are never 1 in the same cycle.

## Timing
- Reset: rst=0 at an edge forces state S0 and all outputs 0 next cycle, from any state including mid-instruction or HALTED.
- Fixed 8 clocks per instruction; no stalls.
- load_ir is high for exactly two consecutive cycles per instruction. This matches the IR's two-byte capture: high byte, then low byte. The IR's byte pointer is returned to 0 by the low cycle that follows.
- IR contents are stable from the edge following the S1 output cycle, before the S3 sample.
- HLT: halt rises in the cycle after the S3 edge and stays high.
- Simultaneous ena=0 and HLT at S3: ena wins, no halt.

## Configuration
- RISC_CTRL_INSTR_CNT_EN defined:
  - Adds output instr_cnt [15:0], reset to 0.
  - Increments by 1 at each S7→S0 transition and wraps 0xFFFF→0x0000.
  - Does not count HLT or instructions aborted by ena=0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package risc_pkg holds:
  - the opcode localparams (HLT..JMP);
  - the step/state encodings S0..S7 and HALTED;
  - the 3-bit opcode width constant, shared with inst_reg, ALU and decoder.
- One natural sub-module, risc_opc_class:
  - combinational, opcode in;
  - outputs is_hlt, is_skz, is_jmp, is_sto, is_alu.
- The FSM core stays in risc_ctrl_fsm.

## Test plan
- Reset/idle: rst=0 three cycles, then rst=1, ena=0 for 5 cycles → all outputs 0, no step advance.
- LDA (opcode 101), ena=1:
  - load_ir/rd/inc_pc high in output cycles 1–2;
  - rd in cycles 5–7, load_acc only in cycle 6;
  - next load_ir in cycle 9.
- STO (110): datactl_ena in cycles 5–7; wr only in cycle 6; rd never high during S4–S7.
- SKZ (001):
  - zero=1 → inc_pc in cycles 6 and 8;
  - zero=0 → inc_pc only in cycles 1–2.
- JMP (111): load_pc in cycles 5–6, inc_pc in cycle 6. HLT (000): halt from cycle 4 onward, persisting 20 cycles with ena toggling. Then rst=0 → halt=0.
- Abort, plus counter when the macro is defined: drop ena at S5 of ADD → outputs 0 next cycle and restart at S0 when ena=1. With RISC_CTRL_INSTR_CNT_EN, 3 complete ADDs → instr_cnt=3, and a preload near 0xFFFF wraps to 0.
